branch_update_queue: RTL and testbench

BRANCH_UPDATE_QUEUE -- requirements
Module: branch_update_queue

---
 rtl/branch_update_queue.sv | 117 +++++++++++
 tb/tb_branch_update_queue.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_update_queue.sv
// Branch update queue: tracks in-flight predicted branches from IF until
// EX/MEM resolves them, emits predictor updates and front-end redirects.
module branch_update_queue #(
  parameter int GHR_WIDTH = 10,
  parameter int DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alloc_valid,
  output logic                      alloc_ready,
  input  logic [31:0]               alloc_pc,
  input  logic [31:0]               alloc_pred_target,
  input  logic                      alloc_pred_taken,
  input  logic                      alloc_is_cond,
  input  logic [GHR_WIDTH-1:0]      alloc_ghr,
  input  logic                      resolve_valid,
  input  logic                      resolve_taken,
  input  logic [31:0]               resolve_target,
  input  logic                      flush_in,
  output logic                      upd_valid,
  output logic [31:0]               upd_pc,
  output logic                      upd_taken,
  output logic                      upd_is_cond,
  output logic [GHR_WIDTH-1:0]      upd_ghr,
  output logic                      mispredict,
  output logic [31:0]               redirect_pc,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic                      resolve_err,
  output logic [15:0]               mispredict_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  typedef struct packed {
    logic [31:0]          pc;
    logic [31:0]          tgt;
    logic                 taken;
    logic                 is_cond;
    logic [GHR_WIDTH-1:0] ghr;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] head, tail;
  entry_t        hd;
  logic          full, empty, do_alloc, do_res, mp, squash;

  // Accept / pop / mispredict decode for this cycle
  always_comb begin
    hd          = mem[head];
    full        = (occupancy == OW'(DEPTH));
    empty       = (occupancy == '0);
    alloc_ready = !full && !flush_in;
    do_res      = resolve_valid && !empty;
    mp          = do_res && ((resolve_taken != hd.taken) ||
                             (resolve_taken && (resolve_target != hd.tgt)));
    // a mispredict squashes the same-cycle alloc as wrong-path
    squash      = mp || flush_in;
    do_alloc    = alloc_valid && alloc_ready && !mp;
  end

  // Entry storage, written at tail on accepted alloc
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_alloc) begin
      mem[tail] <= '{pc: alloc_pc, tgt: alloc_pred_target, taken: alloc_pred_taken,
                     is_cond: alloc_is_cond, ghr: alloc_ghr};
    end
  end

  // Pointers and occupancy; squash empties the queue by snapping head to tail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else if (squash) begin
      head      <= tail;
      occupancy <= '0;
    end else begin
      if (do_alloc) tail <= tail + PW'(1);
      if (do_res)   head <= head + PW'(1);
      occupancy <= occupancy + OW'(do_alloc) - OW'(do_res);
    end
  end

  // Registered predictor update, redirect and error outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_valid      <= 1'b0;
      upd_pc         <= '0;
      upd_taken      <= 1'b0;
      upd_is_cond    <= 1'b0;
      upd_ghr        <= '0;
      mispredict     <= 1'b0;
      redirect_pc    <= '0;
      resolve_err    <= 1'b0;
      mispredict_cnt <= '0;
    end else begin
      upd_valid   <= do_res;
      mispredict  <= mp;
      resolve_err <= resolve_valid && empty;
      if (do_res) begin
        upd_pc      <= hd.pc;
        upd_taken   <= resolve_taken;
        upd_is_cond <= hd.is_cond;
        upd_ghr     <= hd.ghr;
      end
      if (mp) begin
        redirect_pc <= resolve_taken ? resolve_target : hd.pc + 32'd4;
        if (mispredict_cnt != 16'hFFFF) mispredict_cnt <= mispredict_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_update_queue.sv
// Directed bench for branch_update_queue (DEPTH=4, GHR_WIDTH=10).
module tb_branch_update_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        alloc_valid = 1'b0;
  logic        alloc_ready;
  logic [31:0] alloc_pc = '0;
  logic [31:0] alloc_pred_target = '0;
  logic        alloc_pred_taken = 1'b0;
  logic        alloc_is_cond = 1'b0;
  logic [9:0]  alloc_ghr = '0;
  logic        resolve_valid = 1'b0;
  logic        resolve_taken = 1'b0;
  logic [31:0] resolve_target = '0;
  logic        flush_in = 1'b0;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_is_cond;
  logic [9:0]  upd_ghr;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [2:0]  occupancy;
  logic        resolve_err;
  logic [15:0] mispredict_cnt;

  int total = 0;
  int bad = 0;

  branch_update_queue #(.GHR_WIDTH(10), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_pc(alloc_pc), .alloc_pred_target(alloc_pred_target),
    .alloc_pred_taken(alloc_pred_taken), .alloc_is_cond(alloc_is_cond),
    .alloc_ghr(alloc_ghr),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .resolve_target(resolve_target), .flush_in(flush_in),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_is_cond(upd_is_cond), .upd_ghr(upd_ghr),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .occupancy(occupancy), .resolve_err(resolve_err),
    .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance one clock, sample 1ns after the edge, then drop request strobes
  task automatic tick();
    @(posedge clk);
    #1;
    alloc_valid   = 1'b0;
    resolve_valid = 1'b0;
    flush_in      = 1'b0;
  endtask

  task automatic set_alloc(input logic [31:0] pc, input logic [31:0] tgt,
                           input logic tk, input logic cond, input logic [9:0] ghr);
    alloc_valid = 1'b1; alloc_pc = pc; alloc_pred_target = tgt;
    alloc_pred_taken = tk; alloc_is_cond = cond; alloc_ghr = ghr;
  endtask

  task automatic set_res(input logic tk, input logic [31:0] tgt);
    resolve_valid = 1'b1; resolve_taken = tk; resolve_target = tgt;
  endtask

  initial begin
    // asynchronous reset with no clock edge involved
    #2 rst_n = 1'b0;
    #1;
    chk("rst_upd_valid", 32'(upd_valid), 0);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_mp", 32'(mispredict), 0);
    chk("rst_redirect", redirect_pc, 0);
    chk("rst_err", 32'(resolve_err), 0);
    chk("rst_cnt", 32'(mispredict_cnt), 0);
    chk("rst_ready", 32'(alloc_ready), 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // correct taken prediction
    set_alloc(32'h100, 32'h200, 1, 1, 10'h155); tick();
    chk("a1_occ", 32'(occupancy), 1);
    chk("a1_noupd", 32'(upd_valid), 0);
    set_res(1, 32'h200); tick();
    chk("r1_uv", 32'(upd_valid), 1);
    chk("r1_pc", upd_pc, 32'h100);
    chk("r1_tk", 32'(upd_taken), 1);
    chk("r1_ghr", 32'(upd_ghr), 32'h155);
    chk("r1_cond", 32'(upd_is_cond), 1);
    chk("r1_mp", 32'(mispredict), 0);
    chk("r1_occ", 32'(occupancy), 0);

    // direction mispredict: redirect to pc+4
    set_alloc(32'h104, 32'h180, 1, 1, 10'h0AA); tick();
    set_res(0, 32'h0); tick();
    chk("r2_mp", 32'(mispredict), 1);
    chk("r2_redir", redirect_pc, 32'h108);
    chk("r2_occ", 32'(occupancy), 0);
    chk("r2_cnt", 32'(mispredict_cnt), 1);
    chk("r2_uv", 32'(upd_valid), 1);
    chk("r2_tk", 32'(upd_taken), 0);
    tick();
    chk("r2_mp_pulse", 32'(mispredict), 0);

    // fill, overflow attempt, drain in order across pointer wrap
    set_alloc(32'h400, 0, 0, 1, 10'h001); tick();
    set_alloc(32'h404, 0, 0, 0, 10'h002); tick();
    set_alloc(32'h408, 0, 0, 1, 10'h003); tick();
    set_alloc(32'h40C, 0, 0, 1, 10'h004); tick();
    chk("full_occ", 32'(occupancy), 4);
    chk("full_ready", 32'(alloc_ready), 0);
    set_alloc(32'h500, 0, 0, 1, 10'h005); tick();
    chk("full_drop_occ", 32'(occupancy), 4);
    set_alloc(32'h504, 0, 0, 1, 10'h006); set_res(0, 0); tick();
    chk("d0_pc", upd_pc, 32'h400);
    chk("d0_occ", 32'(occupancy), 3);
    set_res(0, 0); tick();
    chk("d1_pc", upd_pc, 32'h404);
    chk("d1_noncond", 32'(upd_is_cond), 0);
    chk("d1_uv", 32'(upd_valid), 1);
    set_res(0, 0); tick();
    chk("d2_pc", upd_pc, 32'h408);
    set_res(0, 0); tick();
    chk("d3_pc", upd_pc, 32'h40C);
    chk("d3_ghr", 32'(upd_ghr), 32'h004);
    chk("d3_mp", 32'(mispredict), 0);
    chk("d3_occ", 32'(occupancy), 0);

    // simultaneous alloc and correct resolve
    set_alloc(32'h600, 0, 0, 1, 0); tick();
    set_alloc(32'h604, 0, 0, 1, 0); set_res(0, 0); tick();
    chk("sim_pc", upd_pc, 32'h600);
    chk("sim_occ", 32'(occupancy), 1);
    set_res(0, 0); tick();
    chk("sim2_pc", upd_pc, 32'h604);
    chk("sim2_occ", 32'(occupancy), 0);

    // resolve while empty
    set_res(1, 32'h999); tick();
    chk("emp_err", 32'(resolve_err), 1);
    chk("emp_uv", 32'(upd_valid), 0);
    chk("emp_occ", 32'(occupancy), 0);
    tick();
    chk("emp_err_pulse", 32'(resolve_err), 0);

    // alloc into empty queue with same-cycle resolve: resolve sees empty
    set_alloc(32'h700, 0, 0, 1, 0); set_res(0, 0); tick();
    chk("ea_err", 32'(resolve_err), 1);
    chk("ea_uv", 32'(upd_valid), 0);
    chk("ea_occ", 32'(occupancy), 1);
    set_res(0, 0); tick();
    chk("ea_pc", upd_pc, 32'h700);

    // target mispredict with wrong-path alloc in the same cycle
    set_alloc(32'h200, 32'h250, 1, 1, 0); tick();
    set_alloc(32'h300, 0, 0, 1, 0); set_res(1, 32'h260); tick();
    chk("wp_mp", 32'(mispredict), 1);
    chk("wp_redir", redirect_pc, 32'h260);
    chk("wp_occ", 32'(occupancy), 0);
    chk("wp_cnt", 32'(mispredict_cnt), 2);
    set_res(0, 0); tick();
    chk("wp_uv", 32'(upd_valid), 0);
    chk("wp_err", 32'(resolve_err), 1);

    // external flush with a pending resolve
    set_alloc(32'h800, 0, 0, 1, 0); tick();
    set_alloc(32'h804, 0, 0, 1, 0); tick();
    flush_in = 1'b1; set_res(0, 0); set_alloc(32'h808, 0, 0, 1, 0);
    #1;
    chk("fl_ready", 32'(alloc_ready), 0);
    tick();
    chk("fl_uv", 32'(upd_valid), 1);
    chk("fl_pc", upd_pc, 32'h800);
    chk("fl_mp", 32'(mispredict), 0);
    chk("fl_occ", 32'(occupancy), 0);

    // pc+4 wraps at 32 bits
    set_alloc(32'hFFFF_FFFC, 32'h10, 1, 1, 0); tick();
    set_res(0, 0); tick();
    chk("wrap_redir", redirect_pc, 32'h0);
    chk("wrap_cnt", 32'(mispredict_cnt), 3);

    // reset mid-cycle with entries in flight
    set_alloc(32'hA00, 0, 0, 1, 0); tick();
    set_alloc(32'hA04, 0, 0, 1, 0); tick();
    set_alloc(32'hA08, 0, 0, 1, 0); tick();
    set_alloc(32'hA0C, 0, 0, 1, 0); tick();
    set_res(1, 32'h44); tick();
    chk("pre_mp", 32'(mispredict), 1);
    chk("pre_occ", 32'(occupancy), 0);
    set_alloc(32'hB00, 0, 0, 1, 0); tick();
    set_alloc(32'hB04, 0, 0, 1, 0); tick();
    set_alloc(32'hB08, 0, 0, 1, 0); tick();
    set_res(0, 0); tick();
    chk("pre_uv", 32'(upd_valid), 1);
    chk("pre_occ3", 32'(occupancy), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_uv", 32'(upd_valid), 0);
    chk("mr_pc", upd_pc, 0);
    chk("mr_occ", 32'(occupancy), 0);
    chk("mr_mp", 32'(mispredict), 0);
    chk("mr_redir", redirect_pc, 0);
    chk("mr_cnt", 32'(mispredict_cnt), 0);
    @(negedge clk); rst_n = 1'b1;
    tick(); tick();
    chk("post_uv", 32'(upd_valid), 0);
    set_res(0, 0); tick();
    chk("post_res_uv", 32'(upd_valid), 0);
    chk("post_res_err", 32'(resolve_err), 1);
    chk("post_occ", 32'(occupancy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard stop in case the sequence ever stalls
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
